// File: rtl/hispi_sync_decoder.sv
// hispi_sync_decoder: word-level HiSPi receiver front end.
// Finds the 4-word sync sequence (all-ones, zero, zero, code) on lane 0 and
// decodes SOF/SOL/EOL/EOF. It then emits a framed pixel stream with fval/lval,
// per-line/per-frame size statistics and a protocol error pulse.
// Ports:
//   sclk, rst              word clock, synchronous active-high reset
//   din_valid, lane_data   one word per lane; lane k at [k*W +: W]
//   pix_valid, pix_data    registered pixel word, pix_data holds when idle
//   fval, lval             frame / line valid levels
//   sof_p, eof_p, sync_err one-cycle pulses
//   line_width             pixel words in the last completed line
//   frame_lines            lines in the last completed frame
module hispi_sync_decoder #(
  parameter int unsigned c_PER_LANE_WIDTH = 10,
  parameter int unsigned c_LANE_WIDTH     = 4
) (
  input  logic                                     sclk,
  input  logic                                     rst,
  input  logic                                     din_valid,
  input  logic [c_LANE_WIDTH*c_PER_LANE_WIDTH-1:0] lane_data,
  output logic                                     pix_valid,
  output logic [c_LANE_WIDTH*c_PER_LANE_WIDTH-1:0] pix_data,
  output logic                                     fval,
  output logic                                     lval,
  output logic                                     sof_p,
  output logic                                     eof_p,
  output logic                                     sync_err,
  output logic [15:0]                              line_width,
  output logic [15:0]                              frame_lines
);

  localparam int unsigned W  = c_PER_LANE_WIDTH;
  localparam int unsigned DW = c_LANE_WIDTH * c_PER_LANE_WIDTH;

  localparam logic [4:0] CODE_SOF = 5'b00011;
  localparam logic [4:0] CODE_SOL = 5'b00001;
  localparam logic [4:0] CODE_EOL = 5'b00101;
  localparam logic [4:0] CODE_EOF = 5'b00111;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    S_ONES = 3'd1,
    S_Z1   = 3'd2,
    S_Z2   = 3'd3,
    ACTIVE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           pix_valid_q, pix_valid_d;
  logic [DW-1:0]  pix_data_q, pix_data_d;
  logic           fval_q, fval_d;
  logic           lval_q, lval_d;
  logic           sof_q, sof_d;
  logic           eof_q, eof_d;
  logic           err_q, err_d;
  logic [15:0]    line_width_q, line_width_d;
  logic [15:0]    frame_lines_q, frame_lines_d;
  logic [15:0]    pix_cnt_q, pix_cnt_d;
  logic [15:0]    line_cnt_q, line_cnt_d;

  // Lane 0 classification; only lane 0 carries sync decisions.
  logic [W-1:0] lane0;
  logic         is_ones, is_zero, code_hi_ok;
  logic [4:0]   code;

  assign lane0      = lane_data[W-1:0];
  assign is_ones    = &lane0;
  assign is_zero    = ~|lane0;
  assign code_hi_ok = ~|lane0[W-1:5];
  assign code       = lane0[4:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register
  always_ff @(posedge sclk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT:    if (is_ones) state_d = S_ONES;
        S_ONES:  begin
          if (is_ones)      state_d = S_ONES;
          else if (is_zero) state_d = S_Z1;
          else              state_d = HUNT;
        end
        S_Z1:    state_d = is_zero ? S_Z2 : HUNT;
        S_Z2:    begin
          state_d = HUNT;
          if (code_hi_ok && ((code == CODE_SOF) || ((code == CODE_SOL) && fval_q)))
            state_d = ACTIVE;
        end
        ACTIVE:  if (is_ones) state_d = S_ONES;
        default: state_d = HUNT;
      endcase
    end
  end

  // Output / datapath next values; pulses default low, levels and stats hold
  always_comb begin
    pix_valid_d   = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    err_d         = 1'b0;
    pix_data_d    = pix_data_q;
    fval_d        = fval_q;
    lval_d        = lval_q;
    line_width_d  = line_width_q;
    frame_lines_d = frame_lines_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: ;
        S_ONES: begin
          // A broken sync during blanking only matters inside a frame.
          if (!is_ones && !is_zero) begin
            err_d  = fval_q;
            lval_d = 1'b0;
          end
        end
        S_Z1: begin
          if (!is_zero) begin
            err_d  = 1'b1;
            lval_d = 1'b0;
          end
        end
        S_Z2: begin
          lval_d = 1'b0;
          if (!code_hi_ok) begin
            err_d = 1'b1;
          end else begin
            unique case (code)
              CODE_SOF: begin
                sof_d      = 1'b1;
                err_d      = fval_q;
                fval_d     = 1'b1;
                pix_cnt_d  = '0;
                line_cnt_d = '0;
              end
              CODE_SOL: begin
                if (fval_q) pix_cnt_d = '0;
                else        err_d     = 1'b1;
              end
              CODE_EOL: begin
                if (fval_q) begin
                  line_width_d = pix_cnt_q;
                  line_cnt_d   = sat_inc(line_cnt_q);
                end else begin
                  err_d = 1'b1;
                end
              end
              CODE_EOF: begin
                if (fval_q) begin
                  eof_d         = 1'b1;
                  fval_d        = 1'b0;
                  line_width_d  = pix_cnt_q;
                  line_cnt_d    = sat_inc(line_cnt_q);
                  frame_lines_d = sat_inc(line_cnt_q);
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        ACTIVE: begin
          if (is_ones) begin
            lval_d = 1'b0;
          end else begin
            pix_valid_d = 1'b1;
            pix_data_d  = lane_data;
            lval_d      = 1'b1;
            pix_cnt_d   = sat_inc(pix_cnt_q);
          end
        end
        default: lval_d = 1'b0;
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge sclk) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      err_q         <= 1'b0;
      line_width_q  <= '0;
      frame_lines_q <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
    end else begin
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      fval_q        <= fval_d;
      lval_q        <= lval_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      err_q         <= err_d;
      line_width_q  <= line_width_d;
      frame_lines_q <= frame_lines_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign fval        = fval_q;
  assign lval        = lval_q;
  assign sof_p       = sof_q;
  assign eof_p       = eof_q;
  assign sync_err    = err_q;
  assign line_width  = line_width_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_hispi_sync_decoder.sv
// Scoreboarded bench for hispi_sync_decoder: random pixel data and gap
// patterns, a word-level reference model feeding expectation queues, and a
// monitor that pops one expectation per pixel or per event pulse.
module tb_hispi_sync_decoder;

  localparam int unsigned W  = 10;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = W * L;

  localparam logic [W-1:0] C_SOF = W'(10'h003);
  localparam logic [W-1:0] C_SOL = W'(10'h001);
  localparam logic [W-1:0] C_EOL = W'(10'h005);
  localparam logic [W-1:0] C_EOF = W'(10'h007);

  logic          sclk = 1'b0;
  logic          rst;
  logic          din_valid;
  logic [DW-1:0] lane_data;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          fval, lval, sof_p, eof_p, sync_err;
  logic [15:0]   line_width, frame_lines;

  hispi_sync_decoder #(.c_PER_LANE_WIDTH(W), .c_LANE_WIDTH(L)) dut (
    .sclk(sclk), .rst(rst), .din_valid(din_valid), .lane_data(lane_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .fval(fval), .lval(lval),
    .sof_p(sof_p), .eof_p(eof_p), .sync_err(sync_err),
    .line_width(line_width), .frame_lines(frame_lines)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          fval;
  } pix_t;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic        err;
    logic        fval;
    logic        lval;
    logic [15:0] lw;
    logic [15:0] fl;
  } ev_t;

  pix_t pix_q[$];
  ev_t  ev_q[$];

  int checks = 0;
  int errors = 0;
  int pix_seen = 0, sof_seen = 0, eof_seen = 0, err_seen = 0, lval_hi = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many sync words have been matched so far and
  // whether a frame / line is open, and derives outputs from the word rules.
  int   m_matched;   // 0 none, 1..3 sync prefix words, 4 = inside a line body
  bit   m_frame, m_line;
  int   m_pixels, m_lines, m_lw, m_fl;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_matched = 0; m_frame = 0; m_line = 0;
    m_pixels = 0; m_lines = 0; m_lw = 0; m_fl = 0;
  endtask

  task automatic model_word(input logic [DW-1:0] w);
    logic [W-1:0] l0;
    bit ones, zero, sof, eof, err;
    pix_t p;
    ev_t  e;
    l0 = w[W-1:0];
    ones = (l0 == {W{1'b1}});
    zero = (l0 == '0);
    sof = 0; eof = 0; err = 0;
    if (m_matched == 4) begin
      if (ones) begin
        m_matched = 1; m_line = 0;
      end else begin
        m_line = 1;
        m_pixels = sat16(m_pixels + 1);
        p.data = w; p.fval = m_frame;
        pix_q.push_back(p);
      end
    end else if (m_matched == 0) begin
      if (ones) m_matched = 1;
    end else if (m_matched == 1) begin
      if (zero) m_matched = 2;
      else if (!ones) begin m_matched = 0; err = m_frame; m_line = 0; end
    end else if (m_matched == 2) begin
      if (zero) m_matched = 3;
      else begin m_matched = 0; err = 1; m_line = 0; end
    end else begin
      m_matched = 0; m_line = 0;
      if (l0 > 31) err = 1;
      else if (l0 == C_SOF) begin
        sof = 1; err = m_frame; m_frame = 1; m_pixels = 0; m_lines = 0; m_matched = 4;
      end else if (l0 == C_SOL) begin
        if (m_frame) begin m_pixels = 0; m_matched = 4; end
        else err = 1;
      end else if (l0 == C_EOL) begin
        if (m_frame) begin m_lw = m_pixels; m_lines = sat16(m_lines + 1); end
        else err = 1;
      end else if (l0 == C_EOF) begin
        if (m_frame) begin
          eof = 1; m_frame = 0; m_lw = m_pixels;
          m_fl = sat16(m_lines + 1); m_lines = m_fl;
        end else err = 1;
      end else err = 1;
    end
    if (sof || eof || err) begin
      e.sof = sof; e.eof = eof; e.err = err; e.fval = m_frame; e.lval = m_line;
      e.lw = 16'(m_lw); e.fl = 16'(m_fl);
      ev_q.push_back(e);
    end
  endtask

  // Monitor: consume one expectation per presented pixel / event pulse.
  always @(negedge sclk) begin
    if (rst === 1'b0) begin
      if (lval) lval_hi++;
      if (pix_valid) begin
        pix_seen++;
        if (pix_q.size() == 0) begin
          chk("pix_unexpected", 64'(pix_valid), 64'(0));
        end else begin
          pix_t p;
          p = pix_q.pop_front();
          chk("pix_data", 64'(pix_data), 64'(p.data));
          chk("pix_lval", 64'(lval), 64'(1));
          chk("pix_fval", 64'(fval), 64'(p.fval));
        end
      end
      if (sof_p || eof_p || sync_err) begin
        if (sof_p) sof_seen++;
        if (eof_p) eof_seen++;
        if (sync_err) err_seen++;
        if (ev_q.size() == 0) begin
          chk("event_unexpected", 64'({sof_p, eof_p, sync_err}), 64'(0));
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("ev_sof", 64'(sof_p), 64'(e.sof));
          chk("ev_eof", 64'(eof_p), 64'(e.eof));
          chk("ev_err", 64'(sync_err), 64'(e.err));
          chk("ev_fval", 64'(fval), 64'(e.fval));
          chk("ev_lval", 64'(lval), 64'(e.lval));
          chk("ev_line_width", 64'(line_width), 64'(e.lw));
          chk("ev_frame_lines", 64'(frame_lines), 64'(e.fl));
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] pix();
    logic [DW-1:0] w;
    w = rnd();
    if (w[W-1:0] == {W{1'b1}}) w[0] = 1'b0;
    return w;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [W-1:0] l0);
    logic [DW-1:0] w;
    w = rnd();
    w[W-1:0] = l0;
    return w;
  endfunction

  // gm: 0 = no gaps, 1 = invalid cycle before every word, 2 = random gaps
  task automatic send(input logic [DW-1:0] w, input int gm);
    if (gm == 1 || (gm == 2 && $urandom_range(0, 1) == 1)) begin
      din_valid = 1'b0; lane_data = rnd();
      @(posedge sclk); #1;
    end
    din_valid = 1'b1; lane_data = w;
    model_word(w);
    @(posedge sclk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; lane_data = rnd();
    repeat (n) begin @(posedge sclk); #1; end
  endtask

  task automatic sync(input logic [W-1:0] code, input int gm);
    send(mk({W{1'b1}}), gm);
    send(mk('0), gm);
    send(mk('0), gm);
    send(mk(code), gm);
  endtask

  task automatic pixels(input int n, input int gm);
    for (int i = 0; i < n; i++) send(pix(), gm);
  endtask

  task automatic frame(input int nl, input int np, input int gm);
    for (int l = 0; l < nl; l++) begin
      sync((l == 0) ? C_SOF : C_SOL, gm);
      pixels(np, gm);
      sync((l == nl - 1) ? C_EOF : C_EOL, gm);
      if (l != nl - 1)
        for (int k = 0; k < 3; k++) send(mk({W{1'b1}}), gm);
    end
  endtask

  task automatic frame_test(input string tag, input int nl, input int np,
                            input int gm, input bit check_lval);
    int p0, s0, e0, r0, h0;
    p0 = pix_seen; s0 = sof_seen; e0 = eof_seen; r0 = err_seen; h0 = lval_hi;
    frame(nl, np, gm);
    idle(3);
    chk({tag, "_pix_count"}, 64'(pix_seen - p0), 64'(nl * np));
    chk({tag, "_sof_count"}, 64'(sof_seen - s0), 64'(1));
    chk({tag, "_eof_count"}, 64'(eof_seen - e0), 64'(1));
    chk({tag, "_err_count"}, 64'(err_seen - r0), 64'(0));
    chk({tag, "_line_width"}, 64'(line_width), 64'(np));
    chk({tag, "_frame_lines"}, 64'(frame_lines), 64'(nl));
    chk({tag, "_fval_end"}, 64'(fval), 64'(0));
    chk({tag, "_lval_end"}, 64'(lval), 64'(0));
    if (check_lval) chk({tag, "_lval_cycles"}, 64'(lval_hi - h0), 64'(nl * np));
  endtask

  task automatic do_reset();
    din_valid = 1'b0; rst = 1'b1;
    @(posedge sclk); #1;
    model_reset();
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_pix_data", 64'(pix_data), 64'(0));
    chk("rst_fval", 64'(fval), 64'(0));
    chk("rst_lval", 64'(lval), 64'(0));
    chk("rst_sof", 64'(sof_p), 64'(0));
    chk("rst_eof", 64'(eof_p), 64'(0));
    chk("rst_err", 64'(sync_err), 64'(0));
    chk("rst_line_width", 64'(line_width), 64'(0));
    chk("rst_frame_lines", 64'(frame_lines), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    int p0, r0, s0;
    rst = 1'b1; din_valid = 1'b0; lane_data = '0;
    model_reset();
    @(posedge sclk); #1;
    do_reset();

    // Clean frame, then same frame with din_valid toggling
    frame_test("clean", 2, 6, 0, 1'b1);
    frame_test("toggle", 2, 6, 1, 1'b0);

    // Second zero corrupted: line body becomes noise until next SOL
    p0 = pix_seen; r0 = err_seen;
    sync(C_SOF, 0); pixels(6, 0); sync(C_EOL, 0);
    send(mk({W{1'b1}}), 0); send(mk('0), 0); send(mk(W'(1)), 0); send(mk(C_SOL), 0);
    pixels(6, 0); sync(C_EOL, 0);
    sync(C_SOL, 0); pixels(6, 0); sync(C_EOF, 0);
    idle(3);
    chk("corrupt_err_count", 64'(err_seen - r0), 64'(1));
    chk("corrupt_pix_count", 64'(pix_seen - p0), 64'(12));

    // SOL before any SOF
    p0 = pix_seen; r0 = err_seen;
    sync(C_SOL, 0); pixels(5, 0); idle(3);
    chk("solfirst_err_count", 64'(err_seen - r0), 64'(1));
    chk("solfirst_pix_count", 64'(pix_seen - p0), 64'(0));
    chk("solfirst_fval", 64'(fval), 64'(0));
    frame_test("after_sol", 3, 4, 2, 1'b0);

    // Bad codes and back-to-back SOF inside a frame
    r0 = err_seen; s0 = sof_seen;
    sync(C_SOF, 0); pixels(4, 0);
    sync(W'(10'h00B), 0); sync(W'(10'h203), 0);
    sync(C_SOF, 0); pixels(4, 0);
    idle(2);
    chk("badcode_fval", 64'(fval), 64'(1));
    sync(C_EOF, 0); idle(3);
    chk("badcode_err_count", 64'(err_seen - r0), 64'(3));
    chk("badcode_sof_count", 64'(sof_seen - s0), 64'(2));
    chk("badcode_line_width", 64'(line_width), 64'(4));

    // Reset after 3 pixels of line 1
    sync(C_SOF, 0); pixels(3, 0); idle(1);
    do_reset();
    r0 = err_seen;
    pixels(3, 0); sync(C_EOL, 0); idle(3);
    chk("postrst_err_count", 64'(err_seen - r0), 64'(1));
    frame_test("postrst", 2, 5, 0, 1'b1);

    // Random frames with random gaps
    for (int i = 0; i < 4; i++)
      frame_test("rand", int'($urandom_range(1, 4)), int'($urandom_range(1, 8)), 2, 1'b0);

    idle(2);
    chk("pix_queue_empty", 64'(pix_q.size()), 64'(0));
    chk("ev_queue_empty", 64'(ev_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
